encoder_mem_responder: RTL and testbench
========================================

# encoder_mem_responder

Memory-side responder for the encoder's shared read port. It accepts the `mem_rd_en`/`mem_rd_addr` requests that the encoder arbiter issues and queues them in order. It serves them from a single-ported weight SRAM and returns `mem_rd_data`/`mem_rd_valid` in request order. The same SRAM port is shared with a host weight-write port, with read priority and a write-starvation guard.

## Interface
Parameters:
- BUS_WIDTH, 512, data width of read/write words
- MEM_WORDS, 65536, SRAM depth in BUS_WIDTH-bit words
- SRAM_LATENCY, 1, fixed SRAM read latency in cycles (1..4)
- REQ_FIFO_DEPTH, 8, read request queue depth (power of 2, ≥2)
- STARVE_LIMIT, 16, max consecutive read issues while a write is pending

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- mem_rd_en  in  1  read request; one request per cycle it is high
- mem_rd_addr  in  32  byte address; low $clog2(BUS_WIDTH/8) bits ignored
- mem_rd_data  out  BUS_WIDTH  read response data
- mem_rd_valid  out  1  one-cycle pulse per response
- wr_en  in  1  host write request, held until accepted
- wr_addr  in  $clog2(MEM_WORDS)  host write word index
- wr_data  in  BUS_WIDTH  host write data
- wr_ready  out  1  write accepted this cycle (combinational)
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write enable
- sram_addr  out  $clog2(MEM_WORDS)  SRAM word address
- sram_wdata  out  BUS_WIDTH  SRAM write data
- sram_rdata  in  BUS_WIDTH  SRAM read data, valid SRAM_LATENCY cycles after a read strobe
- clear_err  in  1  clears sticky error flags
- overflow  out  1  sticky: a request was dropped because the queue was full
- oor_err  out  1  sticky: a request was out of range
- busy  out  1  queue non-empty or response in flight

## Operation
- Word index = `mem_rd_addr >> $clog2(BUS_WIDTH/8)`. An index ≥ MEM_WORDS is out-of-range (OOR).
- Each cycle with `mem_rd_en`=1 pushes {index, oor} into the FIFO.
  - If the FIFO is full and there is no pop that cycle, the request is dropped and `overflow` is set.
  - A push and a pop in the same cycle on a full FIFO succeed.
- Arbiter, evaluated every cycle:
  - If the FIFO is non-empty and `starve_cnt` < STARVE_LIMIT, pop the head and issue a read. OOR entries pop without asserting `sram_en`.
  - Otherwise, if `wr_en` is high, issue the write, assert `wr_ready`, and clear `starve_cnt`.
  - `starve_cnt` increments on each read issue while `wr_en` is high. It clears when `wr_en` is low.
- Response pipeline: a SRAM_LATENCY-deep shift of {valid, oor} tags follows each issued read. At the tail, `mem_rd_data` <= oor ? 0 : `sram_rdata`, and `mem_rd_valid` pulses for one cycle.
- Responses are strictly in request order, including OOR entries.
- `oor_err` is set when an OOR entry is pushed. `clear_err` clears both sticky flags. If a set and a clear occur in the same cycle, the set wins.
- No read-after-write hazard handling: a host write and an encoder read to the same word in flight are unordered. Software must not write weights during an encode.

## Timing
- Reset values: `mem_rd_data`=0, `mem_rd_valid`=0, `wr_ready`=0, `sram_en`=0, `sram_we`=0, `sram_addr`=0, `sram_wdata`=0, `overflow`=0, `oor_err`=0, `busy`=0. The FIFO is empty, the pipeline is cleared and `starve_cnt`=0.
- Latency: a request captured at the end of cycle N issues in cycle N+1. `mem_rd_valid` is high in cycle N+2+SRAM_LATENCY, which is cycle N+3 at the default.
- Throughput: one response per cycle sustained when no write is pending.
- `sram_*` outputs are registered. `wr_ready` is combinational from FIFO state, `starve_cnt` and `wr_en`.
- Reset mid-operation discards all queued and in-flight requests. No `mem_rd_valid` is produced for them.

## Configuration
- MEM_RESP_STATS_EN defined:
  - Adds outputs `rd_count[31:0]` (reads issued, including OOR) and `wr_count[31:0]` (writes accepted).
  - Both counters saturate at 32'hFFFFFFFF, reset to 0 and are cleared by `clear_err`.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Single read to 0x40 (word 1, SRAM holds 0xA5…A5), SRAM_LATENCY=1, request in cycle 0 -> `mem_rd_valid` high only in cycle 3 with data 0xA5…A5.
- Back-to-back reads to words 0..7 in cycles 0–7 -> 8 consecutive valid pulses in cycles 3–10, in order, with no `overflow`.
- Read at byte address MEM_WORDS*64 between two in-range reads -> three in-order responses, the middle one all-zero, and `oor_err`=1 with no `sram_en` for the middle one.
- Continuous reads with `wr_en` held -> the write is accepted after 16 read issues with `wr_ready` high for exactly one cycle, and reads resume.
- Hold SRAM busy with the write path so the FIFO fills with 8 entries, then push a 9th -> the 9th is dropped, `overflow`=1, 8 responses are returned, and `clear_err` returns `overflow` to 0.
- Assert `rst_n`=0 with 3 requests in flight -> all outputs at reset values next cycle and no `mem_rd_valid` after release.

Source files
------------

// File: rtl/encoder_mem_responder.sv
// encoder_mem_responder: in-order read responder sharing one SRAM port with a host write port.
// Latency: request in cycle N issues in N+1, mem_rd_valid in N+2+SRAM_LATENCY; one response/cycle sustained.
// Backpressure: reads never stall (full queue drops + sticky overflow); writes wait on wr_ready. MEM_RESP_STATS_EN adds counters.

// sync_fifo: generic first-word-fall-through queue, power-of-two depth.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         out_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    output logic         full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign out_vld = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign out_dat = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_vld)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (out_rdy)
                rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld)
            mem[wr_ptr[PW-1:0]] <= in_dat;
    end
endmodule

module encoder_mem_responder #(
    parameter int BUS_WIDTH      = 512,
    parameter int MEM_WORDS      = 65536,
    parameter int SRAM_LATENCY   = 1,
    parameter int REQ_FIFO_DEPTH = 8,
    parameter int STARVE_LIMIT   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_rd_en,
    input  logic [31:0]                  mem_rd_addr,
    output logic [BUS_WIDTH-1:0]         mem_rd_data,
    output logic                         mem_rd_valid,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_WORDS)-1:0] wr_addr,
    input  logic [BUS_WIDTH-1:0]         wr_data,
    output logic                         wr_ready,
    output logic                         sram_en,
    output logic                         sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [BUS_WIDTH-1:0]         sram_wdata,
    input  logic [BUS_WIDTH-1:0]         sram_rdata,
    input  logic                         clear_err,
    output logic                         overflow,
    output logic                         oor_err,
    output logic                         busy
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]                  rd_count,
    output logic [31:0]                  wr_count
`endif
);
    localparam int AW  = $clog2(MEM_WORDS);
    localparam int OFF = $clog2(BUS_WIDTH/8);
    localparam int SW  = $clog2(STARVE_LIMIT+1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic          oor;
        logic [AW-1:0] idx;
    } req_t;

    logic [31:0]             word_idx;
    req_t                    push_dat;
    req_t                    head_dat;
    logic                    head_vld;
    logic                    fifo_full;
    logic                    rd_issue;
    logic                    req_push;
    logic                    req_drop;
    logic [SW-1:0]           starve_cnt;
    logic [SRAM_LATENCY-1:0] pipe_vld;
    logic [SRAM_LATENCY-1:0] pipe_oor;

    assign word_idx     = mem_rd_addr >> OFF;
    assign push_dat.oor = (word_idx >= 32'(MEM_WORDS));
    assign push_dat.idx = word_idx[AW-1:0];

    // Reads win the port unless a pending write has already been passed over STARVE_LIMIT times.
    assign rd_issue = head_vld && (starve_cnt < STARVE_MAX);
    assign wr_ready = wr_en && !rd_issue;
    assign req_push = mem_rd_en && (!fifo_full || rd_issue);
    assign req_drop = mem_rd_en && fifo_full && !rd_issue;
    assign busy     = head_vld || (|pipe_vld);

    sync_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (req_push),
        .in_dat  (push_dat),
        .out_rdy (rd_issue),
        .out_vld (head_vld),
        .out_dat (head_dat),
        .full    (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (!wr_en || wr_ready)
            starve_cnt <= '0;
        else if (rd_issue)
            starve_cnt <= starve_cnt + SW'(1);
    end

    // Address/data hold their last value when the port is idle to avoid needless toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_en <= (rd_issue && !head_dat.oor) || wr_ready;
            sram_we <= wr_ready;
            if (rd_issue && !head_dat.oor)
                sram_addr <= head_dat.idx;
            else if (wr_ready) begin
                sram_addr  <= wr_addr;
                sram_wdata <= wr_data;
            end
        end
    end

    // Tags enter alongside the registered strobe; sram_rdata is sampled as the tag leaves the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            pipe_oor <= '0;
        end else begin
            pipe_vld[0] <= rd_issue;
            pipe_oor[0] <= head_dat.oor;
            for (int i = 1; i < SRAM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_oor[i] <= pipe_oor[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_valid <= 1'b0;
            mem_rd_data  <= '0;
        end else begin
            mem_rd_valid <= pipe_vld[SRAM_LATENCY-1];
            if (pipe_vld[SRAM_LATENCY-1])
                mem_rd_data <= pipe_oor[SRAM_LATENCY-1] ? '0 : sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            oor_err  <= 1'b0;
        end else begin
            overflow <= req_drop | (overflow & ~clear_err);
            oor_err  <= (req_push & push_dat.oor) | (oor_err & ~clear_err);
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (clear_err) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_issue && (rd_count != 32'hFFFF_FFFF))
                rd_count <= rd_count + 32'd1;
            if (wr_ready && (wr_count != 32'hFFFF_FFFF))
                wr_count <= wr_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_encoder_mem_responder.sv
// Directed stimulus for encoder_mem_responder with a transaction-level reference model and literal spot checks.
module tb_encoder_mem_responder;
    localparam int BW = 512;
    localparam int MW = 1024;
    localparam int L  = 1;
    localparam int DEPTH = 8;
    localparam int SL = 16;
    localparam int AW = $clog2(MW);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_rd_en;
    logic [31:0]   mem_rd_addr;
    logic [BW-1:0] mem_rd_data;
    logic          mem_rd_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          wr_ready;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [BW-1:0] sram_wdata;
    logic [BW-1:0] sram_rdata;
    logic          clear_err;
    logic          overflow;
    logic          oor_err;
    logic          busy;

    int vectors = 0;
    int errs = 0;

    encoder_mem_responder #(
        .BUS_WIDTH(BW), .MEM_WORDS(MW), .SRAM_LATENCY(L),
        .REQ_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .clear_err(clear_err), .overflow(overflow), .oor_err(oor_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] init_word(int i);
        logic [31:0] w;
        if (i == 1)
            return {64{8'hA5}};
        w = 32'hC0DE_0000 | i;
        return {16{w}};
    endfunction

    // SRAM: read data follows the registered address; writes land at the falling edge.
    logic [BW-1:0] sram_mem [MW];
    assign sram_rdata = sram_mem[sram_addr];
    initial begin
        for (int i = 0; i < MW; i++)
            sram_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (rst_n && sram_en && sram_we)
                sram_mem[sram_addr] = sram_wdata;
        end
    end

    task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: queue of requests, response schedule by cycle, expected SRAM port activity.
    typedef struct {
        int unsigned idx;
        bit          oor;
    } mreq_t;

    mreq_t         mq[$];
    logic [BW-1:0] ref_mem [MW];
    bit            exp_vld [64];
    logic [BW-1:0] exp_dat [64];
    int            cyc = 0;
    int            m_starve = 0;
    bit            m_ovf = 0;
    bit            m_oor = 0;
    bit            sram_chk = 0;
    bit            exp_en = 0;
    bit            exp_we = 0;
    int unsigned   exp_addr = 0;
    logic [BW-1:0] exp_wdata = '0;

    initial begin
        for (int i = 0; i < MW; i++)
            ref_mem[i] = init_word(i);
    end

    always @(negedge clk) begin
        int slot;
        bit inflight, issue, wacc, ovf_set, oor_set;
        int pre_size;
        mreq_t r;
        int unsigned widx;
        if (!rst_n) begin
            chk("rst_valid", mem_rd_valid, 0);
            chk("rst_data", mem_rd_data, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_sram_en", sram_en, 0);
            chk("rst_sram_we", sram_we, 0);
            chk("rst_sram_addr", sram_addr, 0);
            chk("rst_sram_wdata", sram_wdata, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_oor_err", oor_err, 0);
            chk("rst_busy", busy, 0);
            mq.delete();
            for (int i = 0; i < 64; i++) exp_vld[i] = 0;
            m_starve = 0; m_ovf = 0; m_oor = 0; sram_chk = 0;
        end else begin
            slot = cyc % 64;
            chk("rd_valid", mem_rd_valid, exp_vld[slot]);
            if (exp_vld[slot])
                chk("rd_data", mem_rd_data, exp_dat[slot]);
            exp_vld[slot] = 0;
            chk("overflow", overflow, m_ovf);
            chk("oor_err", oor_err, m_oor);
            inflight = 0;
            for (int k = 1; k <= L; k++)
                if (exp_vld[(cyc + k) % 64]) inflight = 1;
            chk("busy", busy, (mq.size() > 0) || inflight);
            if (sram_chk) begin
                chk("sram_en", sram_en, exp_en);
                if (exp_en) begin
                    chk("sram_we", sram_we, exp_we);
                    chk("sram_addr", sram_addr, exp_addr);
                    if (exp_we)
                        chk("sram_wdata", sram_wdata, exp_wdata);
                end
            end

            issue = (mq.size() > 0) && (m_starve < SL);
            wacc  = !issue && wr_en;
            chk("wr_ready", wr_ready, wacc);

            sram_chk = 1; exp_en = 0; exp_we = 0;
            pre_size = mq.size();
            if (issue) begin
                r = mq.pop_front();
                exp_vld[(cyc + 1 + L) % 64] = 1;
                exp_dat[(cyc + 1 + L) % 64] = r.oor ? '0 : ref_mem[r.idx];
                if (!r.oor) begin
                    exp_en = 1;
                    exp_addr = r.idx;
                end
            end else if (wacc) begin
                exp_en = 1; exp_we = 1;
                exp_addr = wr_addr; exp_wdata = wr_data;
                ref_mem[wr_addr] = wr_data;
            end
            ovf_set = 0; oor_set = 0;
            if (mem_rd_en) begin
                widx = mem_rd_addr / 64;
                if (pre_size < DEPTH || issue) begin
                    r.idx = widx;
                    r.oor = (widx >= MW);
                    mq.push_back(r);
                    oor_set = r.oor;
                end else
                    ovf_set = 1;
            end
            m_ovf = ovf_set || (m_ovf && !clear_err);
            m_oor = oor_set || (m_oor && !clear_err);
            if (!wr_en || wacc) m_starve = 0;
            else if (issue) m_starve++;
            cyc++;
        end
    end

    task automatic drive(bit en, logic [31:0] a);
        @(posedge clk);
        #1;
        mem_rd_en   = en;
        mem_rd_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt, first, ens, waited, pulses;
        bit accepted;
        rst_n = 0; mem_rd_en = 0; mem_rd_addr = '0; wr_en = 0; wr_addr = '0;
        wr_data = '0; clear_err = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        drive(0, 0);

        // Single read of word 1: valid only in cycle 3.
        drive(1, 32'h40);
        for (int k = 1; k <= 4; k++) begin
            drive(0, 0);
            @(negedge clk);
            chk($sformatf("t1_valid_c%0d", k), mem_rd_valid, k == 3);
            if (k == 3) chk("t1_data", mem_rd_data, {64{8'hA5}});
        end

        // Back-to-back reads of words 0..7.
        cnt = 0; first = -1;
        for (int i = 0; i < 13; i++) begin
            drive(i < 8, 32'(i * 64));
            @(negedge clk);
            if (mem_rd_valid) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
        chk("t2_count", cnt, 8);
        chk("t2_first", first, 3);
        chk("t2_overflow", overflow, 0);

        // Out-of-range read between two in-range reads.
        cnt = 0; ens = 0;
        for (int i = 0; i < 8; i++) begin
            drive(i < 3, (i == 1) ? 32'(MW * 64) : 32'((i + 2) * 64));
            @(negedge clk);
            if (mem_rd_valid) cnt++;
            if (sram_en && !sram_we) ens++;
        end
        chk("t3_count", cnt, 3);
        chk("t3_sram_reads", ens, 2);
        chk("t3_oor_err", oor_err, 1);
        drive(0, 0); clear_err = 1;
        drive(0, 0); clear_err = 0;
        @(negedge clk);
        chk("t3_oor_cleared", oor_err, 0);

        // Starvation guard: write waits for exactly SL read issues.
        wr_addr = AW'(500); wr_data = {16{32'h5EED_0001}};
        waited = 0; pulses = 0; accepted = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1, 32'((i % 8) * 64));
            wr_en = (i >= 1) && !accepted;
            @(negedge clk);
            if (wr_ready) begin
                pulses++;
                accepted = 1;
            end else if (wr_en && !accepted)
                waited++;
        end
        drive(0, 0); wr_en = 0;
        chk("t4_waited", waited, SL);
        chk("t4_pulses", pulses, 1);
        repeat (5) drive(0, 0);
        drive(1, 32'(500 * 64));
        repeat (6) drive(0, 0);

        // Fill the queue by holding a write pending under continuous reads.
        wr_addr = AW'(600); wr_data = {16{32'h0BAD_F00D}};
        wr_en = 1;
        for (int i = 0; i < 160; i++)
            drive(1, 32'((i % 16) * 64));
        for (int i = 0; i < 20; i++)
            drive(0, 0);
        wr_en = 0;
        repeat (5) drive(0, 0);
        @(negedge clk);
        chk("t5_overflow", overflow, 1);
        drive(0, 0); clear_err = 1;
        drive(0, 0); clear_err = 0;
        @(negedge clk);
        chk("t5_overflow_cleared", overflow, 0);

        // Reset with requests in flight.
        for (int i = 0; i < 3; i++)
            drive(1, 32'((i + 4) * 64));
        drive(0, 0); rst_n = 0;
        @(negedge clk);
        chk("t6_busy", busy, 0);
        chk("t6_valid", mem_rd_valid, 0);
        drive(0, 0);
        drive(0, 0); rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0);
            @(negedge clk);
            if (mem_rd_valid) cnt++;
        end
        chk("t6_no_valid", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
